// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/acknowledge port shared by the fetch unit (master) and the memory (slave).
interface if_fetch_unit_if #(
  parameter int PC_WIDTH   = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  imem_req;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic                  imem_ack;
  logic [DATA_WIDTH-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, drives a variable-latency imem port, feeds IF/ID.
// Optional build macro IMEM_WATCHDOG_EN adds a sticky no-ack watchdog on if_fault.
module if_fetch_unit #(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  DATA_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int                  WDOG_LIMIT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cu_stall,
  input  logic                  redir_valid,
  input  logic [PC_WIDTH-1:0]   redir_target,
  if_fetch_unit_if.master       imem,
  output logic [PC_WIDTH-1:0]   pc,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  if_valid,
  output logic                  if_stall_req,
  output logic                  if_fault
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state, state_next;
  logic [PC_WIDTH-1:0]   pc_reg, pc_next;
  logic [PC_WIDTH-1:0]   req_addr, req_addr_next;
  logic [DATA_WIDTH-1:0] instr_buf, instr_buf_next;
  logic [PC_WIDTH-1:0]   target;
  logic [PC_WIDTH-1:0]   pc_inc;

  assign target = {redir_target[PC_WIDTH-1:2], 2'b00};
  assign pc_inc = pc_reg + PC_WIDTH'(4);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FETCH;
      pc_reg    <= RESET_PC;
      req_addr  <= RESET_PC;
      instr_buf <= '0;
    end else begin
      state     <= state_next;
      pc_reg    <= pc_next;
      req_addr  <= req_addr_next;
      instr_buf <= instr_buf_next;
    end
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next     = state;
    pc_next        = pc_reg;
    req_addr_next  = req_addr;
    instr_buf_next = instr_buf;
    case (state)
      FETCH: begin
        if (redir_valid) begin
          pc_next = target;
          // an un-acked request cannot be withdrawn; remember it and wait it out
          if (!imem.imem_ack) begin
            req_addr_next = pc_reg;
            state_next    = DRAIN;
          end
        end else if (imem.imem_ack) begin
          if (cu_stall) begin
            instr_buf_next = imem.imem_rdata;
            state_next     = HOLD;
          end else begin
            pc_next = pc_inc;
          end
        end
      end
      HOLD: begin
        if (redir_valid) begin
          pc_next    = target;
          state_next = FETCH;
        end else if (!cu_stall) begin
          pc_next    = pc_inc;
          state_next = FETCH;
        end
      end
      DRAIN: begin
        if (redir_valid) pc_next = target;
        if (imem.imem_ack) state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  always_comb begin
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc_reg;
    pc             = pc_reg;
    if_valid       = 1'b0;
    instr          = '0;
    case (state)
      FETCH: begin
        imem.imem_req = 1'b1;
        // zero-wait bypass: returned data is presented in the ack cycle
        if_valid      = imem.imem_ack;
        instr         = imem.imem_ack ? imem.imem_rdata : '0;
      end
      HOLD: begin
        if_valid = 1'b1;
        instr    = instr_buf;
      end
      DRAIN: begin
        imem.imem_req  = 1'b1;
        imem.imem_addr = req_addr;
      end
      default: ;
    endcase
  end

  assign if_stall_req = !if_valid;

`ifdef IMEM_WATCHDOG_EN
  localparam int WDOG_W = ($clog2(WDOG_LIMIT + 1) > 8) ? $clog2(WDOG_LIMIT + 1) : 8;

  logic [WDOG_W-1:0] wdog_cnt;
  logic              fault_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt <= '0;
      fault_q  <= 1'b0;
    end else if (imem.imem_req && !imem.imem_ack) begin
      if (wdog_cnt != WDOG_W'(WDOG_LIMIT)) wdog_cnt <= wdog_cnt + 1'b1;
      fault_q <= fault_q | (wdog_cnt == WDOG_W'(WDOG_LIMIT - 1));
    end else begin
      wdog_cnt <= '0;
    end
  end

  assign if_fault = fault_q;
`else
  // limit only matters with the watchdog built; the expression folds to constant 0
  assign if_fault = (WDOG_LIMIT < 0);
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed cycle checks, then random traffic against a stream scoreboard.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IMEM_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cu_stall;
  logic        redir_valid;
  logic [31:0] redir_target;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        if_valid;
  logic        if_stall_req;
  logic        if_fault;

  logic        auto_mode, sb_en;
  logic        man_ack, auto_ack;
  logic [31:0] man_rdata, auto_rdata;

  int checks = 0;
  int errors = 0;
  int consumes = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  if_fetch_unit_if #(.PC_WIDTH(32), .DATA_WIDTH(32)) mif ();

  assign mif.imem_ack   = auto_mode ? auto_ack : man_ack;
  assign mif.imem_rdata = auto_mode ? auto_rdata : man_rdata;

  if_fetch_unit #(
    .PC_WIDTH  (32),
    .DATA_WIDTH(32),
    .RESET_PC  (RESET_PC),
    .WDOG_LIMIT(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cu_stall    (cu_stall),
    .redir_valid (redir_valid),
    .redir_target(redir_target),
    .imem        (mif.master),
    .pc          (pc),
    .instr       (instr),
    .if_valid    (if_valid),
    .if_stall_req(if_stall_req),
    .if_fault    (if_fault)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // one clock cycle of directed stimulus; returns at the negedge for sampling
  task automatic cyc(input logic rs, input logic st, input logic rv, input logic [31:0] tg,
                     input logic ak, input logic [31:0] rd);
    @(posedge clk);
    #1;
    reset = rs; cu_stall = st; redir_valid = rv; redir_target = tg;
    man_ack = ak; man_rdata = rd;
    @(negedge clk);
  endtask

  // memory model: random 0-3 cycle latency, spurious acks while idle
  initial begin
    logic req_p, ack_p, rst_p;
    bit busy;
    int lat;
    logic [31:0] held;
    auto_ack = 1'b0; auto_rdata = '0; busy = 1'b0; lat = 0; held = '0;
    forever begin
      @(negedge clk);
      req_p = mif.imem_req; ack_p = mif.imem_ack; rst_p = reset;
      @(posedge clk);
      #1;
      if (rst_p || (req_p && ack_p)) busy = 1'b0;
      auto_ack = 1'b0;
      auto_rdata = $urandom;
      if (mif.imem_req) begin
        if (!busy) begin
          busy = 1'b1;
          lat  = $urandom_range(0, 3);
          held = mif.imem_addr;
        end else if (auto_mode && sb_en) begin
          check("imem_addr_stable", mif.imem_addr, held);
        end
        if (lat == 0) begin
          auto_ack = 1'b1;
          auto_rdata = mem_word(mif.imem_addr);
        end else begin
          lat--;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        auto_ack = 1'b1;
      end
    end
  end

  // monitor: pops the expected instruction stream whenever IF/ID consumes
  initial begin
    int idle;
    logic [31:0] e;
    idle = 0;
    forever begin
      @(negedge clk);
      if (sb_en && !reset) begin
        check("stall_req", if_stall_req, !if_valid);
        if (!if_valid) check("nop_when_invalid", instr, 32'h0);
        check("fault_idle", if_fault, 32'h0);
        if (if_valid && !cu_stall && !redir_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL sb_empty: got consume at pc %h expected none", pc);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", pc, e);
            check("sb_instr", instr, mem_word(e));
            exp_q.push_back(e + 32'd4);
          end
          consumes++;
          idle = 0;
        end else if (++idle > 40) begin
          checks++; errors++;
          $display("FAIL consume_timeout: got 40 idle cycles expected progress");
          idle = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] tgt;
    reset = 1'b1; cu_stall = 1'b0; redir_valid = 1'b0; redir_target = '0;
    man_ack = 1'b0; man_rdata = '0; auto_mode = 1'b0; sb_en = 1'b0;

    // reset state
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("rst_req", mif.imem_req, 1);
    check("rst_addr", mif.imem_addr, RESET_PC);
    check("rst_valid", if_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_stall_req", if_stall_req, 1);

    // zero-wait memory: one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 1, mem_word(32'(i * 4)));
      check("zw_addr", mif.imem_addr, 32'(i * 4));
      check("zw_pc", pc, 32'(i * 4));
      check("zw_valid", if_valid, 1);
      check("zw_instr", instr, mem_word(32'(i * 4)));
    end

    // ack under stall -> HOLD; spurious ack in HOLD is ignored
    cyc(0, 1, 0, 0, 1, 32'h8C01_0004);
    check("hold_entry_instr", instr, 32'h8C01_0004);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 0, 0, (i == 1), 32'hBAD0_BAD0);
      check("hold_req", mif.imem_req, 0);
      check("hold_instr", instr, 32'h8C01_0004);
      check("hold_pc", pc, 32'h10);
      check("hold_valid", if_valid, 1);
    end
    cyc(0, 0, 0, 0, 0, 0);
    check("hold_release_valid", if_valid, 1);
    cyc(0, 0, 0, 0, 0, 0);
    check("after_hold_addr", mif.imem_addr, 32'h14);

    // redirect with an outstanding request -> DRAIN
    for (int a = 32'h14; a < 32'h20; a += 4) cyc(0, 0, 0, 0, 1, mem_word(32'(a)));
    cyc(0, 0, 0, 0, 0, 0);
    check("wait_addr", mif.imem_addr, 32'h20);
    cyc(0, 0, 1, 32'h103, 0, 0);
    check("redir_cycle_valid", if_valid, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("drain_req", mif.imem_req, 1);
    check("drain_addr", mif.imem_addr, 32'h20);
    check("drain_pc", pc, 32'h100);
    cyc(0, 0, 0, 0, 1, 32'hDEAD_BEEF);
    check("drain_ack_valid", if_valid, 0);
    check("drain_ack_instr", instr, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("after_drain_addr", mif.imem_addr, 32'h100);

    // redirect beats consume in HOLD
    cyc(0, 1, 0, 0, 1, mem_word(32'h100));
    cyc(0, 0, 1, 32'h200, 0, 0);
    check("hold_redir_pc", pc, 32'h100);
    cyc(0, 0, 0, 0, 0, 0);
    check("hold_redir_addr", mif.imem_addr, 32'h200);

    // pc wrap, then reset mid-wait
    cyc(0, 0, 1, 32'hFFFF_FFFC, 1, mem_word(32'h200));
    cyc(0, 0, 0, 0, 1, mem_word(32'hFFFF_FFFC));
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_valid", if_valid, 1);
    cyc(0, 0, 0, 0, 0, 0);
    check("wrap_addr", mif.imem_addr, 32'h0);
    cyc(0, 0, 1, 32'h40, 1, mem_word(32'h0));
    cyc(0, 0, 0, 0, 0, 0);
    check("wait40_addr", mif.imem_addr, 32'h40);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("midrst_addr", mif.imem_addr, RESET_PC);
    check("midrst_valid", if_valid, 0);

    // watchdog: ack withheld after reset
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      check("wdog_fault", if_fault, 32'(WD_ON && (k == 9)));
    end
    cyc(0, 0, 0, 0, 1, mem_word(RESET_PC));
    cyc(0, 0, 0, 0, 0, 0);
    check("wdog_sticky", if_fault, 32'(WD_ON));
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("wdog_reset_clear", if_fault, 0);

    // random traffic against the stream scoreboard
    cyc(1, 0, 0, 0, 0, 0);
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    auto_mode = 1'b1;
    sb_en = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk);
      #1;
      reset = 1'b0;
      cu_stall = ($urandom_range(0, 3) == 0);
      redir_valid = ($urandom_range(0, 15) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
      redir_target = tgt;
      if (redir_valid) begin
        exp_q.delete();
        exp_q.push_back({tgt[31:2], 2'b00});
      end
    end
    @(negedge clk);
    sb_en = 1'b0;
    check("consume_count_min", 32'(consumes >= 300), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register.
- Owns the architectural fetch PC and drives a req/ack instruction-memory port that tolerates variable latency.
- Presents pc/instr/if_valid to IF/ID; advances when the control unit does not stall.
- Accepts branch/jump redirects from ID/EX and discards fetches that are in flight when a redirect arrives.

Parameters:
PC_WIDTH, 32, width of PC and memory address
DATA_WIDTH, 32, instruction width
RESET_PC, 32'h0000_0000, fetch address after reset
WDOG_LIMIT, 255, watchdog threshold in cycles (used only with IMEM_WATCHDOG_EN)

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  synchronous, active-high
cu_stall  input  1  control-unit stall; IF/ID is not accepting this cycle
redir_valid  input  1  redirect request (taken branch, j, jal, jr)
redir_target  input  PC_WIDTH  redirect address; bits [1:0] forced to 0
imem_req  output  1  memory request outstanding
imem_addr  output  PC_WIDTH  request address
imem_ack  input  1  one-cycle pulse; imem_rdata valid in the same cycle
imem_rdata  input  DATA_WIDTH  returned instruction
pc  output  PC_WIDTH  PC of the presented instruction (to IF/ID)
instr  output  DATA_WIDTH  presented instruction; 0 (NOP) when if_valid=0
if_valid  output  1  pc/instr are a real instruction
if_stall_req  output  1  equals !if_valid; tells the control unit that fetch is starved
if_fault  output  1  sticky watchdog fault; constant 0 without IMEM_WATCHDOG_EN

Behaviour:
- Registers: pc_reg (next PC to present), req_addr (address of the outstanding request), instr_buf, and state in {FETCH, HOLD, DRAIN}.
- Reset (sync): state=FETCH, pc_reg=req_addr=RESET_PC, instr_buf=0, watchdog=0, if_fault=0.
  - First cycle after reset: imem_req=1, imem_addr=RESET_PC, if_valid=0, instr=0.
  - Reset asserted mid-transaction abandons it. Any ack arriving after reset is ignored unless state is FETCH with imem_req=1.
- The instruction is "consumed" at a posedge where if_valid=1 and cu_stall=0 and redir_valid=0.
- FETCH:
  - Outputs: imem_req=1, imem_addr=pc_reg, pc=pc_reg.
  - if_valid=imem_ack (zero-wait bypass); instr=imem_rdata when ack, else 0.
  - redir_valid=1 and ack=1: data dropped; pc_reg<=target; stay FETCH.
  - redir_valid=1 and ack=0: req_addr<=pc_reg; pc_reg<=target; go to DRAIN.
  - ack=1 and consumed: pc_reg<=pc_reg+4; stay FETCH. This gives 1 instruction/cycle with zero-wait memory.
  - ack=1 and cu_stall=1: instr_buf<=imem_rdata; go to HOLD.
  - ack=0: stay FETCH.
- HOLD:
  - Outputs: imem_req=0, if_valid=1, instr=instr_buf, pc=pc_reg.
  - redir_valid=1: pc_reg<=target; go to FETCH. Redirect beats consume, and the buffered instruction is dropped.
  - Consumed: pc_reg<=pc_reg+4; go to FETCH.
  - cu_stall=1: hold all values.
- DRAIN:
  - Outputs: imem_req=1, imem_addr=req_addr, if_valid=0, instr=0, pc=pc_reg.
  - Request stays asserted until acked (the memory may not be abandoned).
  - ack=1: data discarded; go to FETCH. The new fetch starts the next cycle.
  - redir_valid=1 (with or without ack): pc_reg<=target (last redirect wins).
- Arithmetic: pc+4 wraps modulo 2^PC_WIDTH (32'hFFFF_FFFC -> 0); no fault.
- imem_ack while imem_req=0 is ignored.
- cu_stall has no effect when if_valid=0.

Optional Feature:
IMEM_WATCHDOG_EN
- Defined:
  - 8-bit-or-wider counter increments each cycle that imem_req=1 and imem_ack=0; clears on ack, on a HOLD cycle, and on reset.
  - When the counter reaches WDOG_LIMIT, if_fault is set and stays set until reset. Fetch behaviour is unchanged.
- Undefined: no counter is built; if_fault is tied to 0.

Test Plan:
1. Reset, then zero-wait memory (ack every req cycle), cu_stall=0 -> imem_addr/pc = 0x0,0x4,0x8,0xC on consecutive cycles, if_valid=1 each cycle.
2. Ack at pc 0x10 with rdata 0x8C010004 while cu_stall=1 for 3 cycles -> HOLD: instr=0x8C010004, imem_req=0 for 3 cycles; on release, next imem_addr=0x14.
3. 3-cycle-latency memory, request at 0x20 outstanding, redir_valid with target 0x103 -> DRAIN with imem_addr=0x20 until ack; acked data dropped (if_valid=0); next imem_addr=0x100.
4. In HOLD, redir_valid=1 (target 0x200) with cu_stall=0 in the same cycle -> buffered instruction dropped; next imem_addr=0x200, not pc+4.
5. pc=0xFFFF_FFFC consumed -> next imem_addr=0x0. Reset asserted while waiting at 0x40 -> next cycle imem_addr=RESET_PC, if_valid=0.
6. IMEM_WATCHDOG_EN with WDOG_LIMIT=8, ack withheld -> if_fault=1 after 8 req cycles; stays 1 after a later ack; cleared only by reset.
